// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Brief    : Shared RV32I load/store size codes and responder FSM encoding.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lane_align
//  Brief    : Byte/halfword lane selection, load extension, store byte enables.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        fmt_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_illegal;
    logic        w_misaligned;

    always_comb begin
        w_byte       = 8'(rword >> {addr_lo, 3'b000});
        w_half       = addr_lo[1] ? rword[31:16] : rword[15:0];
        w_misaligned = ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
        w_illegal    = 1'b0;
        byte_en      = 4'b0000;
        wdata_lane   = 32'd0;
        load_data    = 32'd0;
        if (write) begin
            // Replicated store data lines up with whichever lanes are enabled.
            case (funct3)
                SB: begin
                    byte_en    = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                SH: begin
                    byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wdata_lane = {2{wdata[15:0]}};
                end
                SW: begin
                    byte_en    = 4'b1111;
                    wdata_lane = wdata;
                end
                default: w_illegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                LB:      load_data = {{24{w_byte[7]}}, w_byte};
                LH:      load_data = {{16{w_half[15]}}, w_half};
                LW:      load_data = rword;
                LBU:     load_data = {24'd0, w_byte};
                LHU:     load_data = {16'd0, w_half};
                default: w_illegal = 1'b1;
            endcase
        end
        fmt_err = w_illegal || w_misaligned;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Fixed-latency RV32I data-memory responder with error reporting.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [3:0] CNT_MAX   = 4'hF;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_write;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [2:0]    r_funct3;
    logic          r_resp_valid;
    logic          r_resp_err;
    logic [31:0]   r_resp_rdata;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_src_write;
    logic [31:0]   w_src_addr;
    logic [31:0]   w_src_wdata;
    logic [2:0]    w_src_funct3;
    logic          w_in_range;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [3:0]    w_byte_en;
    logic [31:0]   w_wdata_lane;
    logic [31:0]   w_load_data;
    logic          w_fmt_err;
    logic          w_err;
    logic [31:0]   w_merged;

    assign req_ready  = (r_state != ST_WAIT);
    assign busy       = (r_state == ST_WAIT) || ((r_state == ST_RESP) && req_valid);
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

    // With single-cycle latency the RESP-entry edge is the accept edge itself,
    // so the transaction is taken straight from the request port.
    if (LATENCY == 1) begin : g_src_direct
        assign w_src_write  = req_write;
        assign w_src_addr   = req_addr;
        assign w_src_wdata  = req_wdata;
        assign w_src_funct3 = req_funct3;
        assign w_enter_resp = w_accept;
    end else begin : g_src_captured
        assign w_src_write  = r_write;
        assign w_src_addr   = r_addr;
        assign w_src_wdata  = r_wdata;
        assign w_src_funct3 = r_funct3;
        assign w_enter_resp = (r_state == ST_WAIT) && (r_cnt >= WAIT_LAST);
    end

    assign w_in_range = ({2'b00, w_src_addr[31:2]} < 32'(DEPTH_WORDS));
    assign w_idx      = w_src_addr[AW+1:2];
    assign w_rword    = w_in_range ? mem[w_idx] : 32'd0;
    assign w_err      = w_fmt_err || !w_in_range;

    dmem_lane_align u_lane_align (
        .addr_lo    (w_src_addr[1:0]),
        .funct3     (w_src_funct3),
        .write      (w_src_write),
        .wdata      (w_src_wdata),
        .rword      (w_rword),
        .byte_en    (w_byte_en),
        .wdata_lane (w_wdata_lane),
        .load_data  (w_load_data),
        .fmt_err    (w_fmt_err)
    );

    always_comb begin
        w_merged = w_rword;
        for (int i = 0; i < 4; i++) begin
            if (w_byte_en[i]) w_merged[8*i +: 8] = w_wdata_lane[8*i +: 8];
        end
    end

    // Storage is deliberately not reset; only a clean RESP entry commits.
    always_ff @(posedge clk) begin
        if (reset && w_enter_resp && w_src_write && !w_err) begin
            mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            r_resp_valid <= w_enter_resp;
            r_resp_err   <= w_enter_resp && w_err;
            r_resp_rdata <= (w_enter_resp && !w_src_write && !w_err) ? w_load_data : 32'd0;
            if (w_accept) begin
                r_write  <= req_write;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_cnt    <= 4'd0;
                r_state  <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end else begin
                case (r_state)
                    ST_WAIT: begin
                        if (r_cnt >= WAIT_LAST) r_state <= ST_RESP;
                        if (r_cnt != CNT_MAX)   r_cnt   <= r_cnt + 4'd1;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
